memory_stage_controller: RTL and testbench

MEMORY_STAGE_CONTROLLER -- requirements
Module: memory_stage_controller

---
 rtl/memory_stage_controller_pkg.sv | 15 +
 rtl/memory_stage_controller_if.sv | 31 +++
 rtl/memory_stage_controller_aligner.sv | 21 ++
 rtl/memory_stage_controller.sv | 94 +++++++++
 tb/tb_memory_stage_controller.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_controller_pkg.sv
// defaultParameters: shared funct3 encodings, FSM state enum and lane helpers for the memory stage
package defaultParameters;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
    return size == 2'b00 ? 4'b0001 << off : size == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] d);
    return size == 2'b00 ? {4{d[7:0]}} : size == 2'b01 ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/memory_stage_controller_if.sv
// memory_stage_controller_if: MEM-stage pipeline controls plus data-bus handshake
// slave: the controller (takes pipeline/bus inputs, drives bus request and results)
// master: the pipeline/bus environment
interface memory_stage_controller_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
  logic                  accessValid;
  logic                  flush;
  logic                  memoryReadEnable;
  logic                  memoryWriteEnable;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] storeData;
  logic                  memReq;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic [3:0]            memByteEnable;
  logic                  memReady;
  logic [DATA_WIDTH-1:0] memRdata;
  logic                  stall;
  logic [DATA_WIDTH-1:0] loadData;
  logic                  loadValid;
  logic                  accessFault;
  modport slave (
    input  accessValid, flush, memoryReadEnable, memoryWriteEnable, funct3, address, storeData, memReady, memRdata,
    output memReq, memWe, memAddr, memWdata, memByteEnable, stall, loadData, loadValid, accessFault
  );
  modport master (
    output accessValid, flush, memoryReadEnable, memoryWriteEnable, funct3, address, storeData, memReady, memRdata,
    input  memReq, memWe, memAddr, memWdata, memByteEnable, stall, loadData, loadValid, accessFault
  );
endinterface

// File: rtl/memory_stage_controller_aligner.sv
// load_data_aligner: picks the addressed byte/halfword of a bus word and sign/zero-extends it
// i_funct3: access size/sign, i_offset: address[1:0], i_rdata: bus word, o_data: extended result
module load_data_aligner
  import defaultParameters::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  always_comb begin
    w_byte = i_rdata[{i_offset, 3'b000} +: 8];
    w_half = i_rdata[{i_offset[1], 4'b0000} +: 16];
    o_data = i_funct3 == F3_B  ? {{24{w_byte[7]}}, w_byte} :
             i_funct3 == F3_H  ? {{16{w_half[15]}}, w_half} :
             i_funct3 == F3_BU ? {24'b0, w_byte} :
             i_funct3 == F3_HU ? {16'b0, w_half} : i_rdata;
  end
endmodule

// File: rtl/memory_stage_controller.sv
// memory_stage_controller: MEM-stage load/store sequencer driving a single-outstanding data bus
// clock/reset: rising-edge clock, sync active-high reset; bus: pipeline controls, bus handshake, stall and load results
module memory_stage_controller
  import defaultParameters::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                     clock,
  input logic                     reset,
  memory_stage_controller_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  state_t                r_state, w_next;
  logic [CW-1:0]         r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_f3;
  logic                  r_we, r_flushed, r_timeout;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata, r_load_data;
  logic [31:0]           w_ld_data;
  logic w_idle, w_busy, w_done, w_req, w_legal, w_addr_ok, w_start, w_bad, w_timeout;
  load_data_aligner u_aligner (
    .i_funct3(r_f3),
    .i_offset(r_addr[1:0]),
    .i_rdata (bus.memRdata),
    .o_data  (w_ld_data)
  );
  // A request held while reset is high must neither stall nor fault.
  always_comb begin
    w_idle    = r_state == IDLE;
    w_busy    = r_state == BUSY;
    w_done    = r_state == DONE;
    w_req     = !reset && w_idle && bus.accessValid && !bus.flush && (bus.memoryReadEnable || bus.memoryWriteEnable);
    w_legal   = bus.memoryReadEnable ? bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU} : bus.funct3 inside {F3_B, F3_H, F3_W};
    w_addr_ok = bus.funct3[1:0] == 2'b01 ? !bus.address[0] : bus.funct3[1:0] == 2'b10 ? bus.address[1:0] == 2'b00 : 1'b1;
    w_start   = w_req && (bus.memoryReadEnable ^ bus.memoryWriteEnable) && w_legal && w_addr_ok;
    w_bad     = w_req && !w_start;
    w_timeout = w_busy && !bus.memReady && r_count == LAST;
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = w_idle ? (w_start ? BUSY : IDLE) : w_busy ? ((bus.memReady || w_timeout) ? DONE : BUSY) : IDLE;
  end
  always_comb begin
    bus.stall         = w_start || w_busy;
    bus.memReq        = w_busy;
    bus.memWe         = r_we;
    bus.memAddr       = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    bus.memWdata      = r_wdata;
    bus.memByteEnable = r_be;
    bus.loadData      = r_load_data;
    bus.loadValid     = w_done && !r_we && !r_flushed && !r_timeout;
    bus.accessFault   = w_bad || (w_done && r_timeout && !r_flushed);
  end
  // loadData is registered on the BUSY->DONE edge so it holds outside DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count     <= '0;
      r_addr      <= '0;
      r_f3        <= '0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_flushed   <= 1'b0;
      r_timeout   <= 1'b0;
      r_load_data <= '0;
    end else begin
      if (w_start) begin
        r_addr    <= bus.address;
        r_f3      <= bus.funct3;
        r_we      <= bus.memoryWriteEnable;
        r_be      <= byte_enable(bus.funct3[1:0], bus.address[1:0]);
        r_wdata   <= lane_replicate(bus.funct3[1:0], bus.storeData);
        r_flushed <= 1'b0;
        r_timeout <= 1'b0;
        r_count   <= '0;
      end
      if (w_busy) begin
        r_count <= r_count + 1'b1;
        if (bus.flush) r_flushed <= 1'b1;
        if (w_timeout) begin
          r_timeout   <= 1'b1;
          r_load_data <= '0;
        end else if (bus.memReady && !r_we) r_load_data <= w_ld_data;
      end
    end
  end
endmodule

// File: tb/tb_memory_stage_controller.sv
// tb_memory_stage_controller: directed self-checking bench for memory_stage_controller
module tb_memory_stage_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  memory_stage_controller_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();
  memory_stage_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  int checks = 0;
  int failures = 0;
  int r_stall, r_req;
  logic [31:0] r_addr, r_wdata, r_ld;
  logic [3:0] r_be;
  logic r_we, r_lv, r_af;

  task automatic idle_inputs;
    bus.accessValid = 0; bus.flush = 0; bus.memoryReadEnable = 0; bus.memoryWriteEnable = 0;
    bus.funct3 = 0; bus.address = 0; bus.storeData = 0; bus.memReady = 0; bus.memRdata = 0;
  endtask

  task automatic start_inputs(input logic rd, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    bus.accessValid = 1; bus.memoryReadEnable = rd; bus.memoryWriteEnable = we;
    bus.funct3 = f3; bus.address = a; bus.storeData = sd;
  endtask

  // Runs one access; ready_at/flush_at are BUSY cycle numbers (0 = never). Ends #1 into the DONE cycle.
  task automatic run_access(input logic rd, input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input int ready_at, input int flush_at, input logic [31:0] rdata);
    @(negedge clock);
    start_inputs(rd, we, f3, a, sd);
    r_stall = 0; r_req = 0;
    #1 if (bus.stall) r_stall++;
    @(negedge clock);
    bus.accessValid = 0; bus.memoryReadEnable = 0; bus.memoryWriteEnable = 0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (c == 1) begin
        r_addr = bus.memAddr; r_wdata = bus.memWdata; r_be = bus.memByteEnable; r_we = bus.memWe;
      end
      if (!bus.memReq) begin
        if (bus.stall) r_stall++;
        r_lv = bus.loadValid; r_ld = bus.loadData; r_af = bus.accessFault;
        break;
      end
      if (bus.stall) r_stall++;
      r_req++;
      bus.flush = (c == flush_at);
      if (c == ready_at) begin
        bus.memReady = 1; bus.memRdata = rdata;
      end
      @(negedge clock);
      bus.memReady = 0; bus.flush = 0;
      if (c == 20) begin
        checks++; failures++;
        $display("FAIL access_bound memReq still high after %0d cycles, required completion", c);
      end
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clock);
    start_inputs(1, 0, 3'b010, 32'h100, 0);
    #1;
    checks++; if (bus.memReq !== 1'b0) begin failures++; $display("FAIL reset_memReq got=%b exp=0", bus.memReq); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
    checks++; if (bus.accessFault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", bus.accessFault); end
    checks++; if (bus.loadValid !== 1'b0) begin failures++; $display("FAIL reset_loadValid got=%b exp=0", bus.loadValid); end
    checks++; if ({bus.memAddr, bus.memWdata} !== 64'h0) begin failures++; $display("FAIL reset_addr_wdata got=%h %h exp=0 0", bus.memAddr, bus.memWdata); end
    checks++; if ({bus.memByteEnable, bus.memWe} !== 5'h0) begin failures++; $display("FAIL reset_be_we got=%h %b exp=0 0", bus.memByteEnable, bus.memWe); end
    checks++; if (bus.loadData !== 32'h0) begin failures++; $display("FAIL reset_loadData got=%h exp=0", bus.loadData); end
    @(negedge clock);
    idle_inputs();
    reset = 0;
    #1;
    checks++; if (bus.memReq !== 1'b0) begin failures++; $display("FAIL reset_no_start got=%b exp=0", bus.memReq); end
  endtask

  task automatic test_load_word;
    run_access(1, 0, 3'b010, 32'h100, 0, 3, 0, 32'hDEADBEEF);
    checks++; if (r_stall !== 4) begin failures++; $display("FAIL lw_stall_cycles got=%0d exp=4", r_stall); end
    checks++; if (r_req !== 3) begin failures++; $display("FAIL lw_req_cycles got=%0d exp=3", r_req); end
    checks++; if (r_addr !== 32'h100) begin failures++; $display("FAIL lw_memAddr got=%h exp=00000100", r_addr); end
    checks++; if (r_be !== 4'b1111 || r_we !== 1'b0) begin failures++; $display("FAIL lw_be_we got=%b %b exp=1111 0", r_be, r_we); end
    checks++; if (r_lv !== 1'b1 || r_af !== 1'b0) begin failures++; $display("FAIL lw_done_flags got=%b %b exp=1 0", r_lv, r_af); end
    checks++; if (r_ld !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_loadData got=%h exp=deadbeef", r_ld); end
    @(negedge clock); #1;
    checks++; if (bus.loadData !== 32'hDEADBEEF || bus.loadValid !== 1'b0) begin failures++; $display("FAIL lw_hold got=%h %b exp=deadbeef 0", bus.loadData, bus.loadValid); end
  endtask

  task automatic test_load_byte_half;
    run_access(1, 0, 3'b000, 32'h103, 0, 1, 0, 32'h80FF0000);
    checks++; if (r_be !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", r_be); end
    checks++; if (r_ld !== 32'hFFFFFF80 || r_lv !== 1'b1) begin failures++; $display("FAIL lb_loadData got=%h %b exp=ffffff80 1", r_ld, r_lv); end
    run_access(1, 0, 3'b100, 32'h103, 0, 1, 0, 32'h80FF0000);
    checks++; if (r_ld !== 32'h00000080) begin failures++; $display("FAIL lbu_loadData got=%h exp=00000080", r_ld); end
    run_access(1, 0, 3'b001, 32'h102, 0, 2, 0, 32'h80011234);
    checks++; if (r_be !== 4'b1100 || r_addr !== 32'h100) begin failures++; $display("FAIL lh_be_addr got=%b %h exp=1100 00000100", r_be, r_addr); end
    checks++; if (r_ld !== 32'hFFFF8001) begin failures++; $display("FAIL lh_loadData got=%h exp=ffff8001", r_ld); end
    run_access(1, 0, 3'b101, 32'h102, 0, 1, 0, 32'h80011234);
    checks++; if (r_ld !== 32'h00008001) begin failures++; $display("FAIL lhu_loadData got=%h exp=00008001", r_ld); end
  endtask

  task automatic test_store;
    run_access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 2, 0, 32'hFFFFFFFF);
    checks++; if (r_we !== 1'b1 || r_be !== 4'b1100) begin failures++; $display("FAIL sh_we_be got=%b %b exp=1 1100", r_we, r_be); end
    checks++; if (r_wdata !== 32'hABCDABCD || r_addr !== 32'h200) begin failures++; $display("FAIL sh_wdata_addr got=%h %h exp=abcdabcd 00000200", r_wdata, r_addr); end
    checks++; if (r_lv !== 1'b0 || r_af !== 1'b0 || r_stall !== 3) begin failures++; $display("FAIL sh_done got=lv%b af%b stall%0d exp=lv0 af0 stall3", r_lv, r_af, r_stall); end
    run_access(0, 1, 3'b000, 32'h101, 32'hCAFE0077, 1, 0, 0);
    checks++; if (r_be !== 4'b0010 || r_wdata !== 32'h77777777) begin failures++; $display("FAIL sb_be_wdata got=%b %h exp=0010 77777777", r_be, r_wdata); end
    run_access(0, 1, 3'b010, 32'h300, 32'h13579BDF, 1, 0, 0);
    checks++; if (r_be !== 4'b1111 || r_wdata !== 32'h13579BDF) begin failures++; $display("FAIL sw_be_wdata got=%b %h exp=1111 13579bdf", r_be, r_wdata); end
  endtask

  task automatic test_faults;
    logic [2:0] f3s [4] = '{3'b010, 3'b100, 3'b010, 3'b011};
    logic [31:0] as [4] = '{32'h101, 32'h0, 32'h0, 32'h0};
    logic [1:0] dirs [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      start_inputs(dirs[i][1], dirs[i][0], f3s[i], as[i], 0);
      #1;
      checks++; if ({bus.accessFault, bus.memReq, bus.stall} !== 3'b100) begin failures++; $display("FAIL fault_%0d got=af%b req%b stall%b exp=af1 req0 stall0", i, bus.accessFault, bus.memReq, bus.stall); end
      @(negedge clock);
      idle_inputs();
      #1;
      checks++; if ({bus.accessFault, bus.memReq} !== 2'b00) begin failures++; $display("FAIL fault_%0d_after got=af%b req%b exp=af0 req0", i, bus.accessFault, bus.memReq); end
    end
    @(negedge clock);
    start_inputs(0, 0, 3'b010, 32'h100, 0);
    #1;
    checks++; if ({bus.accessFault, bus.stall} !== 2'b00) begin failures++; $display("FAIL no_enable got=af%b stall%b exp=af0 stall0", bus.accessFault, bus.stall); end
    idle_inputs();
  endtask

  task automatic test_flush;
    @(negedge clock);
    start_inputs(1, 0, 3'b010, 32'h101, 0);
    bus.flush = 1;
    #1;
    checks++; if ({bus.accessFault, bus.stall} !== 2'b00) begin failures++; $display("FAIL flush_idle_fault got=af%b stall%b exp=af0 stall0", bus.accessFault, bus.stall); end
    bus.address = 32'h100;
    @(negedge clock);
    idle_inputs();
    #1;
    checks++; if (bus.memReq !== 1'b0) begin failures++; $display("FAIL flush_idle_start got=%b exp=0", bus.memReq); end
    run_access(1, 0, 3'b010, 32'h20, 0, 2, 1, 32'h11111111);
    checks++; if (r_req !== 2) begin failures++; $display("FAIL flush_busy_req got=%0d exp=2", r_req); end
    checks++; if ({r_lv, r_af} !== 2'b00) begin failures++; $display("FAIL flush_busy_done got=lv%b af%b exp=lv0 af0", r_lv, r_af); end
  endtask

  task automatic test_timeout;
    run_access(1, 0, 3'b010, 32'h10, 0, 0, 0, 0);
    checks++; if (r_req !== 4) begin failures++; $display("FAIL timeout_req got=%0d exp=4", r_req); end
    checks++; if (r_stall !== 5) begin failures++; $display("FAIL timeout_stall got=%0d exp=5", r_stall); end
    checks++; if ({r_af, r_lv} !== 2'b10) begin failures++; $display("FAIL timeout_flags got=af%b lv%b exp=af1 lv0", r_af, r_lv); end
    checks++; if (r_ld !== 32'h0) begin failures++; $display("FAIL timeout_loadData got=%h exp=0", r_ld); end
    @(negedge clock); #1;
    checks++; if (bus.accessFault !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%b exp=0", bus.accessFault); end
  endtask

  task automatic test_back_to_back;
    run_access(1, 0, 3'b010, 32'h40, 0, 1, 0, 32'h0BADF00D);
    start_inputs(1, 0, 3'b010, 32'h44, 0);
    #1;
    checks++; if ({bus.stall, bus.loadValid} !== 2'b01) begin failures++; $display("FAIL done_ignores_valid got=stall%b lv%b exp=stall0 lv1", bus.stall, bus.loadValid); end
    @(negedge clock);
    idle_inputs();
    bus.memReady = 1; bus.memRdata = 32'hFFFFFFFF;
    #1;
    checks++; if ({bus.memReq, bus.stall} !== 2'b00) begin failures++; $display("FAIL done_no_restart got=req%b stall%b exp=req0 stall0", bus.memReq, bus.stall); end
    @(negedge clock);
    bus.memReady = 0;
    #1;
    checks++; if (bus.loadValid !== 1'b0 || bus.loadData !== 32'h0BADF00D) begin failures++; $display("FAIL ready_outside_busy got=%b %h exp=0 0badf00d", bus.loadValid, bus.loadData); end
  endtask

  task automatic test_reset_busy;
    @(negedge clock);
    start_inputs(1, 0, 3'b010, 32'h100, 0);
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    reset = 1;
    #1;
    checks++; if (bus.memReq !== 1'b1) begin failures++; $display("FAIL rst_busy_before got=%b exp=1", bus.memReq); end
    @(negedge clock);
    #1;
    checks++; if ({bus.memReq, bus.stall, bus.loadValid, bus.accessFault} !== 4'b0) begin failures++; $display("FAIL rst_busy_after got=req%b stall%b lv%b af%b exp=0000", bus.memReq, bus.stall, bus.loadValid, bus.accessFault); end
    checks++; if (bus.memAddr !== 32'h0 || bus.loadData !== 32'h0) begin failures++; $display("FAIL rst_busy_clear got=%h %h exp=0 0", bus.memAddr, bus.loadData); end
    reset = 0;
    @(negedge clock);
    #1;
    checks++; if ({bus.memReq, bus.loadValid, bus.accessFault} !== 3'b0) begin failures++; $display("FAIL rst_busy_idle got=req%b lv%b af%b exp=000", bus.memReq, bus.loadValid, bus.accessFault); end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte_half();
    test_store();
    test_faults();
    test_flush();
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
